// File: rtl/con_pkg.sv
// con_pkg: shared FSM state encodings and error-cause codes for the console dispatcher
package con_pkg;
  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_DEC  = 4'b0010;
  localparam logic [3:0] S_WAIT = 4'b0100;
  localparam logic [3:0] S_REP  = 4'b1000;
  typedef logic [1:0] err_code_t;
  localparam err_code_t CON_ERR_NONE  = 2'b00;
  localparam err_code_t CON_ERR_CH    = 2'b01;
  localparam err_code_t CON_ERR_TO    = 2'b10;
  localparam err_code_t CON_ERR_RANGE = 2'b11;
endpackage

// File: rtl/con_region_dec.sv
// con_region_dec: combinational base-address to one-hot region decoder
//   addr : address to classify
//   area : one-hot region; lowest k with addr < BOUNDS[k], else the last region
module con_region_dec #(
  parameter int N_CH = 3,
  parameter int ADDR_W = 12,
  parameter logic [(N_CH-1)*ADDR_W-1:0] BOUNDS = {12'd128, 12'd64}
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_CH-1:0]   area
);
  // Scanning downward lets the lowest matching bound overwrite higher ones.
  always_comb begin
    area = N_CH'(1) << (N_CH - 1);
    for (int k = N_CH - 2; k >= 0; k--)
      if (addr < BOUNDS[k*ADDR_W +: ADDR_W]) area = N_CH'(1) << k;
  end
endmodule

// File: rtl/con_dispatch.sv
// con_dispatch: console command dispatcher, decodes an address region and runs one sub-engine
//   clk, rst                : clock, synchronous active-high reset
//   i_start_con/im_base_addr: command request (sampled in IDLE) and its base address
//   o_busy                  : high outside IDLE
//   o_done_con/o_error_con  : one-cycle status pulses, om_err_code gives the error cause
//   om_type_area/om_base_addr: decoded region and address of the accepted command
//   om_start                : one-hot start pulse; im_done/im_error: per-channel responses
//   CON_DISPATCH_TIMEOUT_EN : when defined, a WAIT watchdog of TO_CYC cycles reports code 10
module con_dispatch import con_pkg::*; #(
  parameter int N_CH = 3,
  parameter int ADDR_W = 12,
  parameter logic [(N_CH-1)*ADDR_W-1:0] BOUNDS = {12'd128, 12'd64},
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 12'd3072,
  parameter int TO_W = 16,
  parameter logic [15:0] TO_CYC = 16'd1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start_con,
  input  logic [ADDR_W-1:0] im_base_addr,
  output logic              o_busy,
  output logic              o_done_con,
  output logic              o_error_con,
  output logic [1:0]        om_err_code,
  output logic [N_CH-1:0]   om_type_area,
  output logic [ADDR_W-1:0] om_base_addr,
  output logic [N_CH-1:0]   om_start,
  input  logic [N_CH-1:0]   im_done,
  input  logic [N_CH-1:0]   im_error
);
  logic [3:0] state;
  logic [N_CH-1:0] area_dec;
  logic done_k, err_k, oor, to_hit;
  if (TO_CYC < 16'd1 || TO_W < 1) begin : g_bad_to
    $error("con_dispatch: TO_CYC and TO_W must be at least 1");
  end
  con_region_dec #(.N_CH(N_CH), .ADDR_W(ADDR_W), .BOUNDS(BOUNDS)) u_dec (
    .addr(im_base_addr),
    .area(area_dec)
  );
  // Only the selected channel's responses matter.
  assign done_k = |(im_done & om_type_area);
  assign err_k  = |(im_error & om_type_area);
  assign oor    = om_base_addr >= ADDR_LIMIT;
  assign o_busy = state != S_IDLE;
`ifdef CON_DISPATCH_TIMEOUT_EN
  logic [TO_W-1:0] wd;
  assign to_hit = wd == TO_W'(TO_CYC - 16'd1);
  always_ff @(posedge clk)
    if (rst || state == S_DEC) wd <= '0;
    else if (state == S_WAIT && ~&wd) wd <= wd + 1'b1;
`else
  assign to_hit = 1'b0;
`endif
  // An out-of-range command still passes through WAIT (with no start pulse)
  // so its error lands at the same point as a fastest channel response.
  always_ff @(posedge clk)
    if (rst) begin
      state        <= S_IDLE;
      o_done_con   <= 1'b0;
      o_error_con  <= 1'b0;
      om_err_code  <= CON_ERR_NONE;
      om_type_area <= '0;
      om_base_addr <= '0;
      om_start     <= '0;
    end else begin
      o_done_con  <= 1'b0;
      o_error_con <= 1'b0;
      om_err_code <= CON_ERR_NONE;
      om_start    <= '0;
      case (state)
        S_IDLE: if (i_start_con) begin
          state        <= S_DEC;
          om_base_addr <= im_base_addr;
          om_type_area <= area_dec;
        end
        S_DEC: begin
          state <= S_WAIT;
          if (!oor) om_start <= om_type_area;
        end
        S_WAIT: if (oor || done_k || err_k || to_hit) begin
          state       <= S_REP;
          o_done_con  <= !oor && done_k;
          o_error_con <= oor || !done_k;
          om_err_code <= oor ? CON_ERR_RANGE : done_k ? CON_ERR_NONE : err_k ? CON_ERR_CH : CON_ERR_TO;
        end
        S_REP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_con_dispatch.sv
// tb_con_dispatch: directed self-checking bench for con_dispatch
module tb_con_dispatch;
  logic clk = 1'b0, rst = 1'b1, i_start_con = 1'b0;
  logic [11:0] im_base_addr = '0, probe = '0;
  logic [2:0] im_done = '0, im_error = '0, probe_area;
  logic o_busy, o_done_con, o_error_con;
  logic [1:0] om_err_code;
  logic [2:0] om_type_area, om_start;
  logic [11:0] om_base_addr;
  int total = 0, passed = 0, pulses = 0, dones = 0;

  always #5 clk = ~clk;

  con_dispatch #(.TO_CYC(16'd16)) dut (
    .clk(clk), .rst(rst), .i_start_con(i_start_con), .im_base_addr(im_base_addr),
    .o_busy(o_busy), .o_done_con(o_done_con), .o_error_con(o_error_con),
    .om_err_code(om_err_code), .om_type_area(om_type_area), .om_base_addr(om_base_addr),
    .om_start(om_start), .im_done(im_done), .im_error(im_error)
  );

  con_region_dec #(.N_CH(3), .ADDR_W(12), .BOUNDS({12'd128, 12'd64})) u_ref (
    .addr(probe), .area(probe_area)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [11:0] a);
    @(negedge clk);
    i_start_con = 1'b1;
    im_base_addr = a;
    @(negedge clk);
    i_start_con = 1'b0;
  endtask

  initial begin
    probe = 12'd63;  #1 chk("dec_63", probe_area, 3'b001);
    probe = 12'd64;  #1 chk("dec_64", probe_area, 3'b010);
    probe = 12'd127; #1 chk("dec_127", probe_area, 3'b010);
    probe = 12'd128; #1 chk("dec_128", probe_area, 3'b100);
    probe = 12'hFFF; #1 chk("dec_fff", probe_area, 3'b100);
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_outs", {o_done_con, o_error_con, om_err_code, om_type_area, om_base_addr, om_start}, 0);
    rst = 1'b0;
    // 1: region 0 done
    issue(12'h020);
    chk("t1_busy", o_busy, 1);
    chk("t1_area", om_type_area, 3'b001);
    chk("t1_base", om_base_addr, 12'h020);
    chk("t1_nostart", om_start, 0);
    @(negedge clk); chk("t1_start", om_start, 3'b001);
    @(negedge clk); chk("t1_start_off", om_start, 0);
    im_done = 3'b001;
    @(negedge clk);
    chk("t1_done", {o_done_con, o_error_con, om_err_code}, 4'b1000);
    im_done = '0;
    @(negedge clk);
    chk("t1_idle", {o_busy, o_done_con}, 0);
    // 2: done and error together, done wins; then error alone back-to-back
    issue(12'h050);
    chk("t2_area", om_type_area, 3'b010);
    @(negedge clk); chk("t2_start", om_start, 3'b010);
    im_done = 3'b010; im_error = 3'b010;
    @(negedge clk);
    chk("t2_donewins", {o_done_con, o_error_con, om_err_code}, 4'b1000);
    im_done = '0; im_error = '0;
    issue(12'h050);
    @(negedge clk); chk("t2b_start", om_start, 3'b010);
    im_error = 3'b010;
    @(negedge clk);
    chk("t2b_err", {o_done_con, o_error_con, om_err_code}, 4'b0101);
    im_error = '0;
    @(negedge clk);
    chk("t2b_clear", {o_busy, o_error_con, om_err_code}, 0);
    // 4: out of range
    issue(12'hC00);
    chk("t4_base", om_base_addr, 12'hC00);
    @(negedge clk); chk("t4_nostart", {om_start, o_error_con}, 0);
    @(negedge clk); chk("t4_err", {om_start, o_error_con, om_err_code}, 6'b000111);
    @(negedge clk); chk("t4_clear", {o_busy, o_error_con, om_err_code}, 0);
    // 5: request and foreign done ignored during WAIT
    issue(12'h100);
    @(negedge clk); chk("t5_start", om_start, 3'b100);
    i_start_con = 1'b1; im_base_addr = 12'h010; im_done = 3'b001;
    repeat (4) begin
      @(negedge clk);
      if (om_start != 0) pulses++;
      if (o_done_con) dones++;
    end
    chk("t5_pulses", pulses, 0);
    chk("t5_dones", dones, 0);
    chk("t5_base", om_base_addr, 12'h100);
    chk("t5_busy", o_busy, 1);
    i_start_con = 1'b0; im_done = 3'b100;
    @(negedge clk);
    chk("t5_done", {o_done_con, om_type_area}, 4'b1100);
    im_done = '0;
    @(negedge clk);
    chk("t5_idle", o_busy, 0);
    // 3: no response on channel 2
    issue(12'h100);
    @(negedge clk); chk("t3_start", om_start, 3'b100);
`ifdef CON_DISPATCH_TIMEOUT_EN
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (o_error_con || !o_busy) pulses++;
    end
    chk("t3_early", pulses, 0);
    @(negedge clk);
    chk("t3_timeout", {o_error_con, om_err_code}, 3'b110);
    @(negedge clk);
    issue(12'h020);
    @(negedge clk);
`else
    repeat (110) @(negedge clk);
    chk("t3_hold", {o_busy, o_error_con, o_done_con}, 3'b100);
`endif
    // 6: reset mid-WAIT discards the pending response
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst", {o_busy, o_done_con, o_error_con, om_err_code, om_type_area, om_base_addr, om_start}, 0);
    rst = 1'b0; im_done = 3'b111;
    repeat (2) @(negedge clk);
    chk("t6_nopulse", {o_busy, o_done_con, o_error_con}, 0);
    im_done = '0;
    issue(12'h050);
    @(negedge clk); chk("t6_start", om_start, 3'b010);
    im_done = 3'b010;
    @(negedge clk);
    chk("t6_done", {o_done_con, o_error_con, om_err_code}, 4'b1000);
    im_done = '0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
